// File: rtl/mm2s_rd_arbiter.sv
// mm2s_rd_arbiter
// Shares one AXI4 read master between two requesters (s0, s1).
// AR side: a two-state FSM grants one requester at a time, round-robin on
// ties, registers the winner's address/length onto the master AR channel and
// records the owner in an in-order burst queue. R side: beats are routed
// combinationally to the owner at the head of that queue; the head is popped
// on the last beat of each burst.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   s0_/s1_arvalid, arready         requester address handshake
//   s0_/s1_araddr, arlen            requester burst start address / length-1
//   s_rdata, s_rlast                read data / last beat, broadcast
//   s0_/s1_rvalid, rready           per-requester data handshake
//   m_axi_ar*                       AXI master read-address channel
//   m_axi_r*                        AXI master read-data channel
//   err_unexpected_r                sticky: R beat seen with no burst pending
module mm2s_rd_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s0_arvalid,
  output logic                          s0_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]                    s0_arlen,
  input  logic                          s1_arvalid,
  output logic                          s1_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]                    s1_arlen,
  output logic [C_M_AXI_DATA_WIDTH-1:0] s_rdata,
  output logic                          s_rlast,
  output logic                          s0_rvalid,
  input  logic                          s0_rready,
  output logic                          s1_rvalid,
  input  logic                          s1_rready,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic                          err_unexpected_r
);

  localparam int PTR_W = $clog2(C_MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]       state;
  logic             owner_q [C_MAX_OUTSTANDING];  // 0 = s0, 1 = s1
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             last_grant;                   // 1 = s1 was granted last

  logic empty;
  logic full;
  logic grant;
  logic grant_s1;
  logic head;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(C_MAX_OUTSTANDING));

  // Grants only happen in IDLE, so at most one AR every two cycles. Holding
  // off during reset keeps arready low and prevents a push into a queue that
  // is being cleared.
  assign grant    = !reset && (state == ST_IDLE) && !full && (s0_arvalid || s1_arvalid);
  // s1 wins if it is alone, or on a tie when s0 had the previous grant.
  assign grant_s1 = s1_arvalid && (!s0_arvalid || !last_grant);

  assign s0_arready = grant && !grant_s1;
  assign s1_arready = grant && grant_s1;

  assign m_axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;

  // Read-data routing follows the oldest outstanding burst. The empty guard
  // makes stray beats visible to nobody and leaves them unacknowledged.
  assign head         = owner_q[rd_ptr];
  assign s_rdata      = m_axi_rdata;
  assign s_rlast      = m_axi_rlast;
  assign s0_rvalid    = !empty && !head && m_axi_rvalid;
  assign s1_rvalid    = !empty &&  head && m_axi_rvalid;
  assign m_axi_rready = !empty && (head ? s1_rready : s0_rready);
  assign pop          = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      last_grant       <= 1'b1;
      m_axi_arvalid    <= 1'b0;
      m_axi_araddr     <= '0;
      m_axi_arlen      <= '0;
      err_unexpected_r <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (grant) begin
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= grant_s1 ? s1_araddr : s0_araddr;
          m_axi_arlen   <= grant_s1 ? s1_arlen  : s0_arlen;
          last_grant    <= grant_s1;
          state         <= ST_ISSUE;
        end
      end else begin
        if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          state         <= ST_IDLE;
        end
      end

      // A push is always into the tail slot; when the queue held one entry and
      // it pops in the same cycle, rd_ptr lands exactly on the new entry.
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (grant && !pop)      count <= count + 1'b1;
      else if (!grant && pop) count <= count - 1'b1;

      if (m_axi_rvalid && empty) err_unexpected_r <= 1'b1;
    end
  end

  // NOTE: the owner storage is deliberately not reset; a slot is only read
  // while count says it holds a live entry, and it is always written first.
  always_ff @(posedge clk) begin
    if (grant) owner_q[wr_ptr] <= grant_s1;
  end

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Testbench for mm2s_rd_arbiter. A negedge monitor compares every output each
// cycle against a transaction-level model (queue of burst owners, pending-AR
// flag, last winner, sticky error). Scenario tasks drive directed and random
// traffic and add their own checks.
module tb_mm2s_rd_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_arvalid, s1_arvalid;
  logic          s0_arready, s1_arready;
  logic [AW-1:0] s0_araddr, s1_araddr;
  logic [7:0]    s0_arlen, s1_arlen;
  logic [DW-1:0] s_rdata;
  logic          s_rlast;
  logic          s0_rvalid, s1_rvalid;
  logic          s0_rready, s1_rready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic          err_unexpected_r;

  int errors = 0;
  int checks = 0;

  mm2s_rd_arbiter #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s0_arvalid      (s0_arvalid),
    .s0_arready      (s0_arready),
    .s0_araddr       (s0_araddr),
    .s0_arlen        (s0_arlen),
    .s1_arvalid      (s1_arvalid),
    .s1_arready      (s1_arready),
    .s1_araddr       (s1_araddr),
    .s1_arlen        (s1_arlen),
    .s_rdata         (s_rdata),
    .s_rlast         (s_rlast),
    .s0_rvalid       (s0_rvalid),
    .s0_rready       (s0_rready),
    .s1_rvalid       (s1_rvalid),
    .s1_rready       (s1_rready),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arlen     (m_axi_arlen),
    .m_axi_arsize    (m_axi_arsize),
    .m_axi_arburst   (m_axi_arburst),
    .m_axi_rdata     (m_axi_rdata),
    .m_axi_rlast     (m_axi_rlast),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rready    (m_axi_rready),
    .err_unexpected_r(err_unexpected_r)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: list of burst owners in issue order, plus AR bookkeeping.
  // ---------------------------------------------------------------------------
  int            mq[$];
  bit            m_pend   = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [7:0]    m_len    = '0;
  int            m_last   = 1;
  bit            m_err    = 1'b0;
  bit            model_on = 1'b0;

  int   mon_head;
  int   mon_win;
  bit   mon_grant;
  logic mon_rdy;

  always @(negedge clk) begin
    if (model_on) begin
      mon_head  = (mq.size() > 0) ? mq[0] : -1;
      mon_grant = !reset && !m_pend && (mq.size() < MAXO) && (s0_arvalid || s1_arvalid);
      if (s0_arvalid && s1_arvalid) mon_win = (m_last == 0) ? 1 : 0;
      else                          mon_win = s1_arvalid ? 1 : 0;
      mon_rdy = (mon_head == 0) ? s0_rready : (mon_head == 1) ? s1_rready : 1'b0;

      checks += 9;
      if (s0_arready !== (mon_grant && mon_win == 0)) begin
        errors++; $display("FAIL mon_s0_arready t=%0t got=%b exp=%b", $time, s0_arready, mon_grant && mon_win == 0);
      end
      if (s1_arready !== (mon_grant && mon_win == 1)) begin
        errors++; $display("FAIL mon_s1_arready t=%0t got=%b exp=%b", $time, s1_arready, mon_grant && mon_win == 1);
      end
      if (m_axi_arvalid !== m_pend) begin
        errors++; $display("FAIL mon_arvalid t=%0t got=%b exp=%b", $time, m_axi_arvalid, m_pend);
      end
      if (s0_rvalid !== (mon_head == 0 && m_axi_rvalid)) begin
        errors++; $display("FAIL mon_s0_rvalid t=%0t got=%b exp=%b", $time, s0_rvalid, mon_head == 0 && m_axi_rvalid);
      end
      if (s1_rvalid !== (mon_head == 1 && m_axi_rvalid)) begin
        errors++; $display("FAIL mon_s1_rvalid t=%0t got=%b exp=%b", $time, s1_rvalid, mon_head == 1 && m_axi_rvalid);
      end
      if (m_axi_rready !== mon_rdy) begin
        errors++; $display("FAIL mon_rready t=%0t got=%b exp=%b", $time, m_axi_rready, mon_rdy);
      end
      if (s_rdata !== m_axi_rdata) begin
        errors++; $display("FAIL mon_rdata t=%0t got=%h exp=%h", $time, s_rdata, m_axi_rdata);
      end
      if (s_rlast !== m_axi_rlast) begin
        errors++; $display("FAIL mon_rlast t=%0t got=%b exp=%b", $time, s_rlast, m_axi_rlast);
      end
      if (err_unexpected_r !== m_err) begin
        errors++; $display("FAIL mon_err t=%0t got=%b exp=%b", $time, err_unexpected_r, m_err);
      end
      if (m_pend) begin
        checks += 2;
        if (m_axi_araddr !== m_addr) begin
          errors++; $display("FAIL mon_araddr t=%0t got=%h exp=%h", $time, m_axi_araddr, m_addr);
        end
        if (m_axi_arlen !== m_len) begin
          errors++; $display("FAIL mon_arlen t=%0t got=%h exp=%h", $time, m_axi_arlen, m_len);
        end
      end

      // Advance the model to the state after the coming rising edge.
      if (reset) begin
        mq.delete();
        m_pend = 1'b0;
        m_last = 1;
        m_err  = 1'b0;
      end else begin
        if (m_axi_rvalid && mq.size() == 0) m_err = 1'b1;
        if (mon_head >= 0 && m_axi_rvalid && mon_rdy && m_axi_rlast) void'(mq.pop_front());
        if (m_pend) begin
          if (m_axi_arready) m_pend = 1'b0;
        end else if (mon_grant) begin
          mq.push_back(mon_win);
          m_pend = 1'b1;
          m_addr = (mon_win == 1) ? s1_araddr : s0_araddr;
          m_len  = (mon_win == 1) ? s1_arlen  : s0_arlen;
          m_last = mon_win;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    s0_arvalid = 0; s1_arvalid = 0;
    s0_araddr = '0; s1_araddr = '0; s0_arlen = '0; s1_arlen = '0;
    s0_rready = 0;  s1_rready = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Raise arvalid for one requester until it is granted; ok=0 on timeout.
  task automatic request(input int who, input logic [AW-1:0] addr, input logic [7:0] len, output bit ok);
    ok = 0;
    if (who == 0) begin s0_arvalid = 1; s0_araddr = addr; s0_arlen = len; end
    else          begin s1_arvalid = 1; s1_araddr = addr; s1_arlen = len; end
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = (who == 0) ? s0_arready : s1_arready;
      tick();
    end
    s0_arvalid = 0;
    s1_arvalid = 0;
  endtask

  // Complete every outstanding burst with single last-beats.
  task automatic drain();
    int n;
    s0_arvalid = 0; s1_arvalid = 0;
    m_axi_arready = 1; s0_rready = 1; s1_rready = 1; m_axi_rlast = 1;
    n = 0;
    while ((mq.size() > 0 || m_pend) && n < 100) begin
      m_axi_rvalid = (mq.size() > 0);
      m_axi_rdata  = $urandom;
      tick();
      n++;
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL drain_timeout queue=%0d pend=%0d exp=empty", mq.size(), m_pend);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1;
    s0_arvalid = 1; s0_araddr = 32'hDEAD_0000;
    @(negedge clk);
    checks += 7;
    if (s0_arready !== 1'b0)    begin errors++; $display("FAIL reset_arready got=%b exp=0", s0_arready); end
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", m_axi_arvalid); end
    if (m_axi_araddr !== '0)    begin errors++; $display("FAIL reset_araddr got=%h exp=0", m_axi_araddr); end
    if (m_axi_arlen !== '0)     begin errors++; $display("FAIL reset_arlen got=%h exp=0", m_axi_arlen); end
    if (err_unexpected_r !== 0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_unexpected_r); end
    if (m_axi_arsize !== 3'd2)  begin errors++; $display("FAIL arsize got=%0d exp=2", m_axi_arsize); end
    if (m_axi_arburst !== 2'b01) begin errors++; $display("FAIL arburst got=%b exp=01", m_axi_arburst); end
    tick();
    reset = 0;
    s0_arvalid = 0;
    tick();
  endtask

  task automatic test_round_robin();
    int            gnt[$];
    logic [AW-1:0] addrs[$];
    s0_araddr = 32'h0000_1000; s1_araddr = 32'h0000_2000;
    s0_arlen = 8'd0; s1_arlen = 8'd0;
    s0_arvalid = 1; s1_arvalid = 1; m_axi_arready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s0_arready) gnt.push_back(0);
      if (s1_arready) gnt.push_back(1);
      if (m_axi_arvalid) addrs.push_back(m_axi_araddr);
      tick();
    end
    s0_arvalid = 0; s1_arvalid = 0;
    checks += 2;
    if (gnt.size() != MAXO)   begin errors++; $display("FAIL rr_grants got=%0d exp=%0d", gnt.size(), MAXO); end
    if (addrs.size() != MAXO) begin errors++; $display("FAIL rr_ar_count got=%0d exp=%0d", addrs.size(), MAXO); end
    for (int i = 0; i < MAXO && i < gnt.size() && i < addrs.size(); i++) begin
      checks += 2;
      if (gnt[i] != i % 2) begin
        errors++; $display("FAIL rr_owner[%0d] got=s%0d exp=s%0d", i, gnt[i], i % 2);
      end
      if (addrs[i] !== ((i % 2) ? 32'h0000_2000 : 32'h0000_1000)) begin
        errors++; $display("FAIL rr_araddr[%0d] got=%h exp=%h", i, addrs[i], (i % 2) ? 32'h0000_2000 : 32'h0000_1000);
      end
    end
    drain();
  endtask

  task automatic test_routing();
    bit ok0, ok1;
    int beats, s0c, s1c, both;
    m_axi_arready = 1;
    request(0, 32'h0000_3000, 8'd15, ok0);
    request(1, 32'h0000_4000, 8'd3, ok1);
    checks += 2;
    if (!ok0) begin errors++; $display("FAIL route_grant_s0 got=0 exp=1"); end
    if (!ok1) begin errors++; $display("FAIL route_grant_s1 got=0 exp=1"); end
    beats = 0; s0c = 0; s1c = 0; both = 0;
    for (int n = 0; n < 100 && beats < 20; n++) begin
      m_axi_rvalid = 1;
      m_axi_rlast  = (beats == 15 || beats == 19);
      m_axi_rdata  = $urandom;
      s0_rready    = 1'($urandom_range(0, 1));
      s1_rready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s0_rvalid && s1_rvalid) both++;
      if (m_axi_rready) begin
        if (s0_rvalid) s0c++;
        if (s1_rvalid) s1c++;
        beats++;
      end
      tick();
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    checks += 4;
    if (beats != 20) begin errors++; $display("FAIL route_beats got=%0d exp=20", beats); end
    if (s0c != 16)   begin errors++; $display("FAIL route_s0_beats got=%0d exp=16", s0c); end
    if (s1c != 4)    begin errors++; $display("FAIL route_s1_beats got=%0d exp=4", s1c); end
    if (both != 0)   begin errors++; $display("FAIL route_both_valid got=%0d exp=0", both); end
    drain();
  endtask

  task automatic test_ar_stall();
    bit ok;
    int grants;
    m_axi_arready = 0;
    request(0, 32'h0000_5000, 8'd7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_grant got=0 exp=1"); end
    s1_arvalid = 1; s1_araddr = 32'h0000_6000; s1_arlen = 8'd2;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s0_arready || s1_arready) grants++;
      checks += 3;
      if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid c=%0d got=%b exp=1", c, m_axi_arvalid); end
      if (m_axi_araddr !== 32'h0000_5000) begin errors++; $display("FAIL stall_araddr c=%0d got=%h exp=00005000", c, m_axi_araddr); end
      if (m_axi_arlen !== 8'd7) begin errors++; $display("FAIL stall_arlen c=%0d got=%0d exp=7", c, m_axi_arlen); end
      tick();
    end
    checks++;
    if (grants != 0) begin errors++; $display("FAIL stall_extra_grant got=%0d exp=0", grants); end
    m_axi_arready = 1;
    tick();                       // AR accepted, back to IDLE
    @(negedge clk);
    checks++;
    if (s1_arready !== 1'b1) begin errors++; $display("FAIL stall_then_s1 got=%b exp=1", s1_arready); end
    tick();
    s1_arvalid = 0;
    drain();
  endtask

  task automatic test_queue_full();
    int grants;
    m_axi_arready = 1;
    s0_arvalid = 1; s0_araddr = 32'h0000_7000; s0_arlen = 8'd1;
    grants = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (s0_arready) grants++;
      tick();
      s0_araddr = 32'h0000_7000 + 32'(grants * 16);
    end
    checks++;
    if (grants != MAXO) begin errors++; $display("FAIL full_grants got=%0d exp=%0d", grants, MAXO); end
    // Complete the head burst; the queue is still full during that cycle.
    m_axi_rvalid = 1; m_axi_rlast = 1; s0_rready = 1;
    @(negedge clk);
    checks += 2;
    if (s0_arready !== 1'b0)   begin errors++; $display("FAIL full_arready_on_pop got=%b exp=0", s0_arready); end
    if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL full_pop_rready got=%b exp=1", m_axi_rready); end
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    @(negedge clk);
    checks++;
    if (s0_arready !== 1'b1) begin errors++; $display("FAIL full_fifth_grant got=%b exp=1", s0_arready); end
    tick();
    s0_arvalid = 0;
    drain();
  endtask

  task automatic test_unexpected_r();
    m_axi_rvalid = 1; s0_rready = 1; s1_rready = 1; m_axi_rlast = 1;
    @(negedge clk);
    checks += 3;
    if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL unexp_rready got=%b exp=0", m_axi_rready); end
    if (s0_rvalid !== 1'b0)    begin errors++; $display("FAIL unexp_s0_rvalid got=%b exp=0", s0_rvalid); end
    if (err_unexpected_r !== 1'b0) begin errors++; $display("FAIL unexp_err_early got=%b exp=0", err_unexpected_r); end
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (err_unexpected_r !== 1'b1) begin errors++; $display("FAIL unexp_err_sticky c=%0d got=%b exp=1", c, err_unexpected_r); end
      tick();
    end
    pulse_reset();
    @(negedge clk);
    checks++;
    if (err_unexpected_r !== 1'b0) begin errors++; $display("FAIL unexp_err_cleared got=%b exp=0", err_unexpected_r); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok0, ok1;
    m_axi_arready = 1;
    request(0, 32'h0000_8000, 8'd3, ok0);
    request(1, 32'h0000_9000, 8'd3, ok1);
    checks += 2;
    if (!ok0) begin errors++; $display("FAIL midrst_grant_s0 got=0 exp=1"); end
    if (!ok1) begin errors++; $display("FAIL midrst_grant_s1 got=0 exp=1"); end
    m_axi_rvalid = 1; m_axi_rlast = 0; s0_rready = 1;   // one beat into the s0 burst
    tick();
    m_axi_rvalid = 0;
    pulse_reset();
    @(negedge clk);
    checks += 5;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL midrst_arvalid got=%b exp=0", m_axi_arvalid); end
    if (m_axi_araddr !== '0)    begin errors++; $display("FAIL midrst_araddr got=%h exp=0", m_axi_araddr); end
    if (m_axi_arlen !== '0)     begin errors++; $display("FAIL midrst_arlen got=%h exp=0", m_axi_arlen); end
    if (s0_rvalid !== 1'b0)     begin errors++; $display("FAIL midrst_s0_rvalid got=%b exp=0", s0_rvalid); end
    if (m_axi_rready !== 1'b0)  begin errors++; $display("FAIL midrst_rready got=%b exp=0", m_axi_rready); end
    tick();
    // With the queue empty, a beat must be refused and flagged.
    m_axi_rvalid = 1; s0_rready = 1; s1_rready = 1;
    @(negedge clk);
    checks++;
    if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL midrst_queue_empty got=%b exp=0", m_axi_rready); end
    tick();
    m_axi_rvalid = 0;
    pulse_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      s0_arvalid    = 1'($urandom_range(0, 1));
      s1_arvalid    = 1'($urandom_range(0, 1));
      s0_araddr     = $urandom;
      s1_araddr     = $urandom;
      s0_arlen      = 8'($urandom);
      s1_arlen      = 8'($urandom);
      m_axi_arready = ($urandom_range(0, 9) < 7);
      m_axi_rvalid  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      m_axi_rlast   = ($urandom_range(0, 2) == 0);
      m_axi_rdata   = $urandom;
      s0_rready     = 1'($urandom_range(0, 1));
      s1_rready     = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    @(negedge clk);
    checks += 2;
    if (m_axi_arvalid !== 1'b0)    begin errors++; $display("FAIL rand_end_arvalid got=%b exp=0", m_axi_arvalid); end
    if (err_unexpected_r !== 1'b0) begin errors++; $display("FAIL rand_end_err got=%b exp=0", err_unexpected_r); end
    tick();
  endtask

  initial begin
    quiet_inputs();
    reset = 1;
    tick();
    tick();
    model_on = 1;
    test_reset();
    test_round_robin();
    quiet_inputs();
    test_routing();
    quiet_inputs();
    test_ar_stall();
    quiet_inputs();
    test_queue_full();
    quiet_inputs();
    test_unexpected_r();
    quiet_inputs();
    test_reset_mid_burst();
    quiet_inputs();
    test_random();
    quiet_inputs();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
